// File: rtl/ex_muldiv_unit_pkg.sv
// ex_muldiv_unit_pkg: opcode and FSM state encodings shared by the multiply/divide unit.
package ex_muldiv_unit_pkg;
  typedef enum logic [1:0] {OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11} md_op_e;
  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} md_state_e;
  function automatic logic op_is_div(md_op_e op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction
  function automatic logic op_is_signed(md_op_e op);
    return op inside {OP_MULT, OP_DIV};
  endfunction
endpackage

// File: rtl/muldiv_div_step.sv
// muldiv_div_step: one restoring-division bit, shifting a dividend bit into the partial remainder.
module muldiv_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic            dbit_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic            q_o
);
  logic [XLEN:0] shifted, diff;
  assign shifted = {rem_i, dbit_i};
  assign diff    = shifted - {1'b0, divisor_i};
  assign q_o     = !diff[XLEN];
  assign rem_o   = q_o ? diff[XLEN-1:0] : shifted[XLEN-1:0];
endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine producing {hi,lo} with a valid/ready handshake.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 4,
  parameter int DIV_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_src1,
  input  logic [XLEN-1:0] req_src2,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_hi,
  output logic [XLEN-1:0] resp_lo,
  output logic            stallreq
);
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] N_MUL = CW'(XLEN / MUL_STEP);
  localparam logic [CW-1:0] N_DIV = CW'(XLEN / DIV_STEP);

  md_state_e         state_q, state_d;
  md_op_e            op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d, m_q, m_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic              accept, is_div;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN+MUL_STEP-1:0] msum;
  logic [2*XLEN-1:0] mul_next, div_next, fix_val;
  logic [XLEN-1:0]   rc [DIV_STEP+1];
  logic [XLEN-1:0]   dc [DIV_STEP+1];

  assign is_div     = op_is_div(op_q);
  assign req_ready  = (state_q == S_IDLE) || (state_q == S_DONE && resp_ready);
  assign accept     = req_valid && req_ready && !flush;
  assign resp_valid = state_q == S_DONE;
  assign stallreq   = state_q inside {S_PREP, S_CALC, S_FIX};
  assign resp_hi    = resp_valid ? acc_q[2*XLEN-1:XLEN] : '0;
  assign resp_lo    = resp_valid ? acc_q[XLEN-1:0] : '0;

  assign neg_a_d = (state_q == S_PREP) ? op_is_signed(op_q) && a_q[XLEN-1] : neg_a_q;
  assign neg_b_d = (state_q == S_PREP) ? op_is_signed(op_q) && b_q[XLEN-1] : neg_b_q;
  assign mag_a   = neg_a_d ? -a_q : a_q;
  assign mag_b   = neg_b_d ? -b_q : b_q;

  // Radix-2^MUL_STEP shift-add: low bits of acc hold the remaining multiplier digits.
  always_comb begin
    msum = {{MUL_STEP{1'b0}}, acc_q[2*XLEN-1:XLEN]};
    for (int i = 0; i < MUL_STEP; i++)
      msum = msum + (acc_q[i] ? ({{MUL_STEP{1'b0}}, m_q} << i) : '0);
  end
  assign mul_next = {msum, acc_q[XLEN-1:MUL_STEP]};

  assign rc[0] = acc_q[2*XLEN-1:XLEN];
  assign dc[0] = acc_q[XLEN-1:0];
  for (genvar g = 0; g < DIV_STEP; g++) begin : g_div
    logic q;
    muldiv_div_step #(.XLEN(XLEN)) u_step (
      .rem_i    (rc[g]),
      .dbit_i   (dc[g][XLEN-1]),
      .divisor_i(m_q),
      .rem_o    (rc[g+1]),
      .q_o      (q)
    );
    assign dc[g+1] = {dc[g][XLEN-2:0], q};
  end
  assign div_next = {rc[DIV_STEP], dc[DIV_STEP]};

  // Divide by zero bypasses sign fix-up so the raw dividend lands in hi.
  assign fix_val = !is_div ? ((neg_a_q ^ neg_b_q) ? -acc_q : acc_q)
                 : (b_q == '0) ? {a_q, {XLEN{1'b1}}}
                 : {neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN],
                    (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0]};

  always_comb begin
    state_d = state_q;
    op_d    = accept ? md_op_e'(req_op) : op_q;
    a_d     = accept ? req_src1 : a_q;
    b_d     = accept ? req_src2 : b_q;
    m_d     = m_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: state_d = accept ? S_PREP : S_IDLE;
      S_PREP: begin
        m_d     = is_div ? mag_b : mag_a;
        acc_d   = {{XLEN{1'b0}}, is_div ? mag_a : mag_b};
        cnt_d   = is_div ? N_DIV : N_MUL;
        state_d = S_CALC;
      end
      S_CALC: begin
        state_d = (cnt_q == '0) ? S_FIX : S_CALC;
        acc_d   = (cnt_q == '0) ? acc_q : (is_div ? div_next : mul_next);
        cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
      end
      S_FIX: begin
        acc_d   = fix_val;
        state_d = S_DONE;
      end
      S_DONE: state_d = accept ? S_PREP : (resp_ready ? S_IDLE : S_DONE);
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_MULT;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
    end
  end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed vectors with hand-computed results for the multiply/divide unit.
module tb_ex_muldiv_unit;
  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic        req_valid = 1'b0, req_ready, resp_valid, resp_ready = 1'b0, stallreq;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_src1 = '0, req_src2 = '0, resp_hi, resp_lo;
  int          tests = 0, fails = 0;

  ex_muldiv_unit dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_src1(req_src1), .req_src2(req_src2),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_hi(resp_hi), .resp_lo(resp_lo), .stallreq(stallreq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    while (!resp_valid && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic consume();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] hi, input logic [31:0] lo, input int lat);
    int n;
    start(op, a, b);
    check({tag, " stall"}, {63'd0, stallreq}, 64'd1);
    wait_resp(n);
    check({tag, " latency"}, 64'(n), 64'(lat));
    check({tag, " result"}, {resp_hi, resp_lo}, {hi, lo});
    consume();
  endtask

  initial begin
    int  n;
    logic seen;
    logic [63:0] held;
    repeat (2) tick();
    check("reset ready/valid/stall", {61'd0, req_ready, resp_valid, stallreq}, {61'd0, 3'b100});
    check("reset hi/lo", {resp_hi, resp_lo}, 64'd0);
    rst = 1'b0;
    tick();

    run("multu max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 11);
    run("mult -3*5", 2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 11);
    run("mult minint^2", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 11);
    run("div -7/2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 35);
    run("div 7/-2", 2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 35);
    run("divu 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 35);
    run("divu 7/0", 2'b11, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF, 35);
    run("div -8/0", 2'b10, 32'hFFFFFFF8, 32'd0, 32'hFFFFFFF8, 32'hFFFFFFFF, 35);
    run("div overflow", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 35);

    // flush wins over a coincident request in IDLE
    flush = 1'b1; req_valid = 1'b1; req_op = 2'b01;
    tick();
    flush = 1'b0; req_valid = 1'b0;
    check("flush blocks accept", {62'd0, stallreq, req_ready}, 64'd1);

    start(2'b10, 32'd1000, 32'd3);
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush div ready/valid/stall", {61'd0, req_ready, resp_valid, stallreq}, {61'd0, 3'b100});
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      seen |= resp_valid;
      tick();
    end
    check("flush no resp", {63'd0, seen}, 64'd0);
    run("multu 2*3", 2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 11);

    start(2'b01, 32'h12345678, 32'h10);
    wait_resp(n);
    held = {resp_hi, resp_lo};
    check("hold result", held, 64'h0000000123456780);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold valid", {63'd0, resp_valid}, 64'd1);
      check("hold stable", {resp_hi, resp_lo}, 64'h0000000123456780);
    end
    resp_ready = 1'b1; req_valid = 1'b1; req_op = 2'b01; req_src1 = 32'd3; req_src2 = 32'd4;
    tick();
    resp_ready = 1'b0; req_valid = 1'b0;
    check("b2b stall/valid", {62'd0, stallreq, resp_valid}, 64'd2);
    wait_resp(n);
    check("b2b latency", 64'(n), 64'd11);
    check("b2b result", {resp_hi, resp_lo}, 64'd12);
    consume();

    start(2'b10, 32'd50, 32'd7);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst mid ready/valid/stall", {61'd0, req_ready, resp_valid, stallreq}, {61'd0, 3'b100});
    check("rst mid hi/lo", {resp_hi, resp_lo}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
